// File: rtl/trumpet_pkg.sv
// trumpet_pkg: note codes, FSM encoding and valve-fingering decode for the practice controller.
package trumpet_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [4:0] NOTE_NONE = 5'd0;
  localparam logic [4:0] NOTE_C4   = 5'd1;
  localparam logic [4:0] NOTE_CS4  = 5'd2;
  localparam logic [4:0] NOTE_D4   = 5'd3;
  localparam logic [4:0] NOTE_DS4  = 5'd4;
  localparam logic [4:0] NOTE_E4   = 5'd5;
  localparam logic [4:0] NOTE_F4   = 5'd6;
  localparam logic [4:0] NOTE_FS4  = 5'd7;
  localparam logic [4:0] NOTE_G4   = 5'd8;
  localparam logic [4:0] NOTE_GS4  = 5'd9;
  localparam logic [4:0] NOTE_A4   = 5'd10;
  localparam logic [4:0] NOTE_AS4  = 5'd11;
  localparam logic [4:0] NOTE_B4   = 5'd12;
  localparam logic [4:0] NOTE_C5   = 5'd13;
  localparam logic [4:0] NOTE_CS5  = 5'd14;
  localparam logic [4:0] NOTE_D5   = 5'd15;
  localparam logic [4:0] NOTE_DS5  = 5'd16;
  // Airflow selects the harmonic partial; valves (pressed, active-high) lower it chromatically.
  function automatic logic [4:0] decode_note(input logic [2:0] p, input logic [1:0] a);
    logic [4:0] n;
    n = NOTE_NONE;
    case ({a, p})
      5'b01_000: n = NOTE_C4;
      5'b01_111: n = NOTE_CS4;
      5'b01_101: n = NOTE_D4;
      5'b01_011: n = NOTE_DS4;
      5'b01_110: n = NOTE_E4;
      5'b01_100: n = NOTE_F4;
      5'b01_010: n = NOTE_FS4;
      5'b10_000: n = NOTE_G4;
      5'b10_011: n = NOTE_GS4;
      5'b10_110: n = NOTE_A4;
      5'b10_100: n = NOTE_AS4;
      5'b10_010: n = NOTE_B4;
      5'b11_000: n = NOTE_C5;
      5'b11_110: n = NOTE_CS5;
      5'b11_100: n = NOTE_D5;
      5'b11_010: n = NOTE_DS5;
      default:   n = NOTE_NONE;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/trumpet_debounce.sv
// trumpet_debounce: 2-flop synchroniser plus stability debounce for a W-bit vector.
module trumpet_debounce #(
  parameter int W               = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_deb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [W-1:0] r_s1, r_s2, r_prev, r_deb;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic w_take;
  // w_cnt_nxt is the length of the current run of a synchronised value that differs from r_deb
  assign w_cnt_nxt = (r_s2 == r_deb) ? '0 : (r_s2 != r_prev) ? CW'(1) : r_cnt + 1'b1;
  assign w_take = w_cnt_nxt == CW'(DEBOUNCE_CYCLES);
  assign o_deb = r_deb;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_deb  <= '0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_cnt  <= w_take ? '0 : w_cnt_nxt;
      r_deb  <= w_take ? r_s2 : r_deb;
    end
  end
endmodule

// File: rtl/trumpet_practice_ctrl.sv
// trumpet_practice_ctrl: debounces valves/airflow, decodes the played note and scores
// timed attempts to hold a requested target note.
module trumpet_practice_ctrl
  import trumpet_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter int SCORE_W         = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         keys_n,
  input  logic [1:0]         airflow,
  input  logic [4:0]         target_note,
  input  logic               target_valid,
  output logic               target_ready,
  input  logic               clear_score,
  output logic [4:0]         note,
  output logic               match,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss_count,
  output logic [1:0]         state
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [4:0] w_deb;
  state_t r_state;
  logic [4:0] r_note, r_target;
  logic [TW-1:0] r_timer;
  logic [HW-1:0] r_hold;
  logic r_match, r_miss;
  logic [SCORE_W-1:0] r_score, r_miss_cnt;
  logic w_on, w_done, w_tout, w_miss;
  trumpet_debounce #(.W(5), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk  (clock),
    .rst  (reset),
    .i_raw({~keys_n, airflow}),
    .o_deb(w_deb)
  );
  assign w_on   = (r_note == r_target) && (r_note != NOTE_NONE);
  assign w_done = (r_state == HOLD) && w_on && (r_hold == HW'(HOLD_CYCLES - 1));
  assign w_tout = (r_state != IDLE) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
  // A completed hold beats a timeout landing on the same edge
  assign w_miss = w_tout && !w_done;
  assign target_ready = r_state == IDLE;
  assign note         = r_note;
  assign match        = r_match;
  assign miss         = r_miss;
  assign score        = r_score;
  assign miss_count   = r_miss_cnt;
  assign state        = r_state;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_note     <= '0;
      r_target   <= '0;
      r_timer    <= '0;
      r_hold     <= '0;
      r_match    <= 1'b0;
      r_miss     <= 1'b0;
      r_score    <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_note     <= decode_note(w_deb[4:2], w_deb[1:0]);
      r_match    <= w_done;
      r_miss     <= w_miss;
      r_timer    <= (r_state == IDLE) ? '0 : r_timer + 1'b1;
      r_score    <= clear_score ? '0 : (w_done && !(&r_score)) ? r_score + 1'b1 : r_score;
      r_miss_cnt <= clear_score ? '0 : (w_miss && !(&r_miss_cnt)) ? r_miss_cnt + 1'b1 : r_miss_cnt;
      case (r_state)
        IDLE:
          if (target_valid) begin
            r_target <= target_note;
            r_state  <= ARMED;
          end
        ARMED:
          if (w_tout) r_state <= IDLE;
          else if (w_on) begin
            r_hold  <= '0;
            r_state <= HOLD;
          end
        HOLD:
          if (w_done || w_tout) r_state <= IDLE;
          else if (!w_on) begin
            r_hold  <= '0;
            r_state <= ARMED;
          end else r_hold <= r_hold + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trumpet_practice_ctrl.sv
// tb_trumpet_practice_ctrl: directed scenarios plus random play against a windowed reference model.
module tb_trumpet_practice_ctrl;
  localparam int D = 4, H = 8, T = 40, SW = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0] keys_n = 3'b111;
  logic [1:0] airflow = 2'd0;
  logic [4:0] target_note = 5'd0;
  logic target_valid = 1'b0;
  logic clear_score = 1'b0;
  logic target_ready, match, miss;
  logic [4:0] note;
  logic [SW-1:0] score, miss_count;
  logic [1:0] state;
  int errors = 0, checks = 0, cyc = 0;
  logic [4:0] hist[$];
  logic [4:0] m_deb, m_note, m_tgt;
  logic m_busy, m_match, m_miss;
  int m_run, m_el, m_score, m_misses;

  trumpet_practice_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T), .SCORE_W(SW)) dut (
    .clock(clock), .reset(reset), .keys_n(keys_n), .airflow(airflow),
    .target_note(target_note), .target_valid(target_valid), .target_ready(target_ready),
    .clear_score(clear_score), .note(note), .match(match), .miss(miss),
    .score(score), .miss_count(miss_count), .state(state)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] ref_note(input logic [4:0] v);
    logic [2:0] p;
    p = v[4:2];
    case (v[1:0])
      2'd1: return p == 3'b000 ? 5'd1 : p == 3'b111 ? 5'd2 : p == 3'b101 ? 5'd3 : p == 3'b011 ? 5'd4 :
                   p == 3'b110 ? 5'd5 : p == 3'b100 ? 5'd6 : p == 3'b010 ? 5'd7 : 5'd0;
      2'd2: return p == 3'b000 ? 5'd8 : p == 3'b011 ? 5'd9 : p == 3'b110 ? 5'd10 :
                   p == 3'b100 ? 5'd11 : p == 3'b010 ? 5'd12 : 5'd0;
      2'd3: return p == 3'b000 ? 5'd13 : p == 3'b110 ? 5'd14 : p == 3'b100 ? 5'd15 :
                   p == 3'b010 ? 5'd16 : 5'd0;
      default: return 5'd0;
    endcase
  endfunction

  // Raw sample taken k edges ago; anything before reset reads as zero
  function automatic logic [4:0] samp(input int k);
    return (hist.size() >= k) ? hist[hist.size() - k] : 5'd0;
  endfunction

  function automatic logic match_next();
    return m_busy && m_note == m_tgt && m_tgt != 0 && m_run == H;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [4:0] raw, nb, cand, tn;
    logic stable, tv, cs, rs;
    raw = {~keys_n, airflow};
    nb = m_note;
    tv = target_valid;
    tn = target_note;
    cs = clear_score;
    rs = reset;
    @(posedge clock);
    if (rs) begin
      hist.delete();
      m_deb = 0; m_note = 0; m_tgt = 0; m_busy = 0; m_match = 0; m_miss = 0;
      m_run = 0; m_el = 0; m_score = 0; m_misses = 0;
    end else begin
      m_note = ref_note(m_deb);
      cand = samp(2);
      stable = 1'b1;
      for (int k = 3; k <= D + 1; k++) if (samp(k) !== cand) stable = 1'b0;
      if (stable && cand !== m_deb) m_deb = cand;
      m_match = 0;
      m_miss = 0;
      if (!m_busy) begin
        if (tv) begin m_busy = 1; m_tgt = tn; m_run = 0; m_el = 0; end
      end else begin
        m_el++;
        m_run = (nb == m_tgt && m_tgt != 0) ? m_run + 1 : 0;
        if (m_run == H + 1) m_match = 1;
        else if (m_el == T) m_miss = 1;
        if (m_match || m_miss) m_busy = 0;
      end
      if (cs) begin m_score = 0; m_misses = 0; end
      else begin
        if (m_match && m_score < 255) m_score++;
        if (m_miss && m_misses < 255) m_misses++;
      end
      hist.push_back(raw);
      if (hist.size() > D + 2) void'(hist.pop_front());
    end
    #1;
    cyc++;
    chk("note", 32'(note), 32'(m_note));
    chk("state", 32'(state), m_busy ? (m_run > 0 ? 32'd2 : 32'd1) : 32'd0);
    chk("target_ready", 32'(target_ready), 32'(!m_busy));
    chk("match", 32'(match), 32'(m_match));
    chk("miss", 32'(miss), 32'(m_miss));
    chk("score", 32'(score), 32'(m_score));
    chk("miss_count", 32'(miss_count), 32'(m_misses));
  endtask

  task automatic offer(input logic [4:0] tgt);
    target_note = tgt;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
  endtask

  task automatic attempt(input logic [4:0] tgt, input logic clr, output int got);
    got = 0;
    offer(tgt);
    for (int i = 0; i < 60 && got == 0; i++) begin
      clear_score = clr && match_next();
      tick();
      clear_score = 1'b0;
      if (match) got = 1;
    end
  endtask

  initial begin
    int lat, nm, t0, t_brk, t_res, t_m, got, hold_left;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_ready", 32'(target_ready), 1);
    chk("rst_score", 32'(score), 0);
    tick();
    // Scenario 1: D4 with a steady fingering
    keys_n = 3'b010; airflow = 2'd1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (note == 5'd3 && lat == 0) lat = n;
    end
    chk("s1_latency", lat, D + 3);
    // Scenario 2: short glitch is filtered out
    keys_n = 3'b000;
    tick(); tick();
    keys_n = 3'b010;
    repeat (12) tick();
    chk("s2_note", 32'(note), 3);
    // Scenario 3: target G4, then play it
    offer(5'd8);
    keys_n = 3'b111; airflow = 2'd2;
    nm = 0;
    repeat (30) begin tick(); if (match) nm++; end
    chk("s3_matches", nm, 1);
    chk("s3_score", 32'(score), 1);
    chk("s3_ready", 32'(target_ready), 1);
    // Scenario 4: hold broken part-way, then resumed
    offer(5'd8);
    airflow = 2'd1;
    repeat (4) tick();
    airflow = 2'd2;
    t_brk = 0; t_res = 0; t_m = 0;
    for (int i = 0; i < 40 && t_m == 0; i++) begin
      tick();
      if (note != 5'd8 && t_brk == 0) t_brk = cyc;
      if (note == 5'd8 && t_brk != 0 && t_res == 0) t_res = cyc;
      if (match) t_m = cyc;
    end
    chk("s4_broken", 32'(t_brk != 0 && t_res > t_brk), 1);
    chk("s4_gap", t_m - t_res, H + 1);
    // Scenario 5: D#5 never played
    offer(5'd16);
    t0 = cyc; t_m = 0; nm = 0;
    for (int i = 0; i < 60 && t_m == 0; i++) begin
      tick();
      if (miss) t_m = cyc;
      if (match) nm++;
    end
    chk("s5_miss_delay", t_m - t0, T);
    chk("s5_no_match", nm, 0);
    chk("s5_miss_count", 32'(miss_count), 1);
    // Scenario 6: saturate, then clear on the same edge as a match
    for (int i = 0; i < 300 && score != 8'd255; i++) attempt(5'd8, 1'b0, got);
    chk("s6_at_max", 32'(score), 255);
    attempt(5'd8, 1'b0, got);
    chk("s6_sat_match", got, 1);
    chk("s6_sat_hold", 32'(score), 255);
    attempt(5'd8, 1'b1, got);
    chk("s6_clr_match", got, 1);
    chk("s6_clr_score", 32'(score), 0);
    offer(5'd8);
    repeat (3) tick();
    chk("s6_in_hold", 32'(state), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_rst_state", 32'(state), 0);
    chk("s6_rst_pulse", 32'({match, miss}), 0);
    repeat (3) tick();
    // Random play with occasional clears and resets
    hold_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold_left == 0) begin
        keys_n = 3'($urandom);
        airflow = 2'($urandom);
        hold_left = $urandom_range(1, 30);
      end
      hold_left--;
      target_valid = ($urandom_range(0, 3) == 0);
      target_note = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 20)) : m_note;
      clear_score = ($urandom_range(0, 60) == 0);
      reset = ($urandom_range(0, 400) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trumpet_practice_ctrl.md
TRUMPET_PRACTICE_CTRL -- requirements
Module: trumpet_practice_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept an input change (>=1).
REQ-002 Parameter HOLD_CYCLES, default 1000: consecutive cycles the correct note must be held to score (>=1).
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: cycles allowed per attempt before a miss (> HOLD_CYCLES).
REQ-004 Parameter SCORE_W, default 8: width of the score and miss counters.
REQ-005 Port clock, in, 1: the single clock; all state changes on its rising edge.
REQ-006 Port reset, in, 1: synchronous, active-high reset.
REQ-007 Port keys_n, in, 3: raw valve buttons, active-low, asynchronous to clock.
REQ-008 Port airflow, in, 2: raw airflow level, 0 means none; asynchronous.
REQ-009 Port target_note, in, 5: note code to practise.
REQ-010 Port target_valid, in, 1: target_note offered this cycle.
REQ-011 Port target_ready, out, 1: high exactly when state is IDLE.
REQ-012 Port clear_score, in, 1: zero both counters.
REQ-013 Port note, out, 5: registered note code currently played.
REQ-014 Port match, out, 1: one-cycle pulse on a successful attempt.
REQ-015 Port miss, out, 1: one-cycle pulse on a timed-out attempt.
REQ-016 Port score, out, SCORE_W: saturating count of matches.
REQ-017 Port miss_count, out, SCORE_W: saturating count of misses.
REQ-018 Port state, out, 2: encoded FSM state, for display and debug.

Function
REQ-019 keys_n and airflow SHALL each pass through a 2-flop synchroniser; the pressed vector is the inverse of keys_n.
REQ-020 The 5-bit vector {pressed, airflow} SHALL update its debounced copy only after the synchronised value has differed from it and stayed constant for DEBOUNCE_CYCLES cycles; any change restarts the count.
REQ-021 Raw input held constant from cycle t SHALL appear on note at cycle t+3+DEBOUNCE_CYCLES.
REQ-022 Note decode for airflow 1 (pressed -> code): 000->1, 111->2, 101->3, 011->4, 110->5, 100->6, 010->7.
REQ-023 Note decode for airflow 2: 000->8, 011->9, 110->10, 100->11, 010->12.
REQ-024 Note decode for airflow 3: 000->13, 110->14, 100->15, 010->16.
REQ-025 Airflow 0, and any fingering not listed for the current airflow, SHALL decode to 0.
REQ-026 FSM states: IDLE=0, ARMED=1, HOLD=2.
REQ-027 In IDLE with target_valid=1, the block SHALL latch target_note, clear the attempt timer and go to ARMED.
REQ-028 target_valid outside IDLE SHALL be ignored.
REQ-029 In ARMED, when note equals the latched target and is nonzero, the block SHALL clear the hold counter and go to HOLD.
REQ-030 In HOLD, a note different from the target SHALL return the FSM to ARMED with the hold counter cleared.
REQ-031 In HOLD, on the HOLD_CYCLES-th consecutive matching cycle, the block SHALL pulse match, increment score (saturating at all-ones) and go to IDLE.
REQ-032 The attempt timer SHALL run in ARMED and HOLD; on reaching TIMEOUT_CYCLES it SHALL pulse miss, increment miss_count (saturating) and go to IDLE.
REQ-033 If hold completion and timeout occur in the same cycle, match wins and no miss is produced.
REQ-034 clear_score SHALL zero both counters the next cycle, overriding any same-cycle increment; it SHALL not affect the FSM.
REQ-035 A target of 0 SHALL never match and SHALL always end in a miss at timeout.

Reset
REQ-036 Reset SHALL set state=IDLE; note, score, miss_count, match, miss, all timers, synchronisers and debounced vector to 0; target_ready=1 the following cycle.
REQ-037 Reset asserted mid-attempt SHALL abort the attempt without a match or miss pulse.

Structure
REQ-038 Package trumpet_pkg SHALL hold the note-code constants, the FSM state encoding and the fingering decode function.
REQ-039 Sub-module trumpet_debounce, parametrised by width and DEBOUNCE_CYCLES, SHALL implement REQ-019 and REQ-020.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, TIMEOUT_CYCLES=40)
REQ-040 Scenario 1: airflow=1, keys_n=3'b010 steady -> note=3 at cycle t+7, and note=3 for the rest of the test.
REQ-041 Scenario 2: a 2-cycle glitch on keys_n -> note unchanged.
REQ-042 Scenario 3: target 8, then play airflow=2 with no valves -> exactly one match, score=1, target_ready returns high.
REQ-043 Scenario 4: target 8, correct note broken after 5 cycles, then resumed -> HOLD restarts, match only after 8 further cycles.
REQ-044 Scenario 5: target 16, never played -> miss exactly 40 cycles after acceptance, miss_count=1.
REQ-045 Scenario 6: score at 255 plus a match in the same cycle as clear_score -> score=0; reset in HOLD -> state=0 and no pulse.
